upcntr_mod: RTL and testbench
=============================

Name: upcntr_mod

Overview:
- Parametrised modulo up/down counter FSM; next generation of the team's 2-bit trigger-driven up-counter.
- Adds configurable width and modulus, direction control, wrap or saturate mode, synchronous load, terminal-count pulse and saturation flag.
- Used as the generic sequencing/state counter in FSM exercises and as a tick divider feeding display and timing blocks.

Parameters:
- WIDTH, 4, bit width of the count/state output.
- MODULUS, 10, number of count states; count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- trigger  input  1  count enable; one step per rising clk edge while high.
- dir  input  1  1 = count up, 0 = count down; sampled with trigger.
- wrap_en  input  1  1 = wrap at the boundary, 0 = saturate at the boundary.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- state  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle per wrap.
- sat  output  1  saturation flag, registered.

Behaviour:
- Reset: reset=0 forces state=0, tc=0, sat=0 immediately, with no clock edge needed. Reset release is clean; the first step happens at the first rising edge after release with trigger=1.
- All outputs are registered. There are no combinational paths from inputs to outputs. Step latency is 1 edge.
- Per-edge priority, highest first: load, then trigger, then hold.
- Load: state <= load_val if load_val <= MODULUS-1, else MODULUS-1 (clamped). Also tc<=0 and sat<=0. trigger is ignored on that edge.
- Up step (trigger=1, dir=1, state < MODULUS-1): state <= state+1, tc<=0, sat<=0.
- Down step (trigger=1, dir=0, state > 0): state <= state-1, tc<=0, sat<=0.
- Upper boundary (trigger=1, dir=1, state = MODULUS-1):
  - wrap_en=1: state<=0, tc<=1.
  - wrap_en=0: state holds, sat<=1, tc<=0.
- Lower boundary (trigger=1, dir=0, state = 0):
  - wrap_en=1: state<=MODULUS-1, tc<=1.
  - wrap_en=0: state holds, sat<=1, tc<=0.
- Hold (trigger=0, load=0): state holds, tc<=0, sat keeps its value.
- tc is high for exactly one cycle, aligned with the cycle in which state shows the wrapped value. Back-to-back wraps (MODULUS=2, continuous trigger) keep tc high on every wrapping edge.
- sat stays set until cleared by a load or a successful step. A direction change away from the boundary therefore clears it on that step.
- dir and wrap_en may change on any cycle; each takes effect on the edge where it is sampled.
- Arithmetic is done at WIDTH bits. The counter never produces a value >= MODULUS, including when MODULUS = 2**WIDTH, where natural overflow is handled by the boundary compare and never by carry.
- Reset asserted mid-operation overrides load and trigger asynchronously.

Test Plan:
- Up/wrap count: reset=0 for 13 ns then 1; trigger=1, dir=1, wrap_en=1, clk period 10 ns -> state 0,1,...,9,0,1; tc=1 only in the cycle state=0 following 9; sat=0 throughout.
- Down/wrap count: from state=0, dir=0, wrap_en=1 -> state 9,8,...,0,9; tc=1 only in the cycle showing 9 after 0.
- Up/saturate: wrap_en=0, dir=1 from 7 -> state 8,9,9,9; sat=1 from the edge after reaching 9; tc never high; then dir=0 -> state 8, sat=0.
- Load: load=1, load_val=12 -> state=9 (clamped). load=1, load_val=5 with trigger=1, dir=1 on the same edge -> state=5, no increment. trigger=0 for 3 cycles -> state stays 5.
- Async reset: at state=6, pull reset low 3 ns after an edge -> state=0, tc=0, sat=0 before the next edge. Hold low across 2 edges with trigger=1 -> state remains 0.
- Corner: WIDTH=2, MODULUS=4 (original 2-bit behaviour) with trigger=1 -> state 0,1,2,3,0 and tc on each wrap. WIDTH=1, MODULUS=2 -> state toggles every edge with tc high on every edge where state returns to 0.

Source files
------------

// File: rtl/upcntr_mod.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : upcntr_mod
//  Description : Parametrised modulo up/down counter. Counts over
//                0..MODULUS-1 with direction control, wrap-or-saturate
//                behaviour at both boundaries, a clamped synchronous load,
//                a one-cycle terminal-count pulse and a sticky saturation
//                flag. All outputs are registered.
//  Revision    : 1.0 - initial release (supersedes the fixed 2-bit counter)
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     bit width of the count output
//    MODULUS   number of count states, 2 <= MODULUS <= 2**WIDTH
//  Ports
//    clk       in   1      system clock, rising edge
//    reset     in   1      asynchronous reset, active low
//    trigger   in   1      count enable, one step per edge while high
//    dir       in   1      1 = up, 0 = down
//    wrap_en   in   1      1 = wrap at boundary, 0 = saturate
//    load      in   1      synchronous load strobe (beats trigger)
//    load_val  in   WIDTH  value to load, clamped to MODULUS-1
//    state     out  WIDTH  current count
//    tc        out  1      terminal-count pulse, one cycle per wrap
//    sat       out  1      saturation flag, sticky until load or step
// ============================================================================
module upcntr_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             dir,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             tc,
    output logic             sat
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------------
    generate
        if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $error("upcntr_mod: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
        end
    endgenerate

    // Highest legal count. When MODULUS == 2**WIDTH this is all-ones, so the
    // boundary compare below catches the top value before any carry occurs.
    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_state;
    logic             r_tc;
    logic             r_sat;

    logic [WIDTH-1:0] w_state_nxt;
    logic             w_tc_nxt;
    logic             w_sat_nxt;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max       = (r_state == c_MAX);
    assign w_at_min       = (r_state == c_ZERO);
    assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: load, then trigger, then hold.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tc_nxt    = 1'b0;
        w_sat_nxt   = r_sat;

        if (load) begin
            w_state_nxt = w_load_clamped;
            w_sat_nxt   = 1'b0;
        end else if (trigger) begin
            if (dir) begin
                if (!w_at_max) begin
                    w_state_nxt = r_state + c_ONE;
                    w_sat_nxt   = 1'b0;
                end else if (wrap_en) begin
                    w_state_nxt = c_ZERO;
                    w_tc_nxt    = 1'b1;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_sat_nxt   = 1'b1;
                end
            end else begin
                if (!w_at_min) begin
                    w_state_nxt = r_state - c_ONE;
                    w_sat_nxt   = 1'b0;
                end else if (wrap_en) begin
                    w_state_nxt = c_MAX;
                    w_tc_nxt    = 1'b1;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_sat_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ZERO;
            r_tc    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign state = r_state;
    assign tc    = r_tc;
    assign sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_upcntr_mod.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_upcntr_mod
//  Description : Directed scoreboard bench for upcntr_mod. Main instance
//                uses WIDTH=4/MODULUS=10; two corner instances use
//                WIDTH=2/MODULUS=4 and WIDTH=1/MODULUS=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upcntr_mod;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_trig, m_dir, m_wrap, m_load;
    logic [3:0] m_lv;
    logic [3:0] m_state;
    logic       m_tc, m_sat;

    logic       c_trig;
    logic [1:0] c2_state;
    logic       c2_tc, c2_sat;
    logic [0:0] c1_state;
    logic       c1_tc, c1_sat;

    always #5 clk = ~clk;

    upcntr_mod #(.WIDTH(4), .MODULUS(10)) u_main (
        .clk(clk), .reset(reset), .trigger(m_trig), .dir(m_dir),
        .wrap_en(m_wrap), .load(m_load), .load_val(m_lv),
        .state(m_state), .tc(m_tc), .sat(m_sat)
    );

    upcntr_mod #(.WIDTH(2), .MODULUS(4)) u_c2 (
        .clk(clk), .reset(reset), .trigger(c_trig), .dir(1'b1),
        .wrap_en(1'b1), .load(1'b0), .load_val(2'b00),
        .state(c2_state), .tc(c2_tc), .sat(c2_sat)
    );

    upcntr_mod #(.WIDTH(1), .MODULUS(2)) u_c1 (
        .clk(clk), .reset(reset), .trigger(c_trig), .dir(1'b1),
        .wrap_en(1'b1), .load(1'b0), .load_val(1'b0),
        .state(c1_state), .tc(c1_tc), .sat(c1_sat)
    );

    typedef struct {
        string      tag;
        int         sel;   // 0 = main, 1 = W2/M4, 2 = W1/M2
        logic [3:0] st;
        logic       tc;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input int sel, input int st,
                        input bit etc, input bit esat);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.st  = 4'(st);
        e.tc  = etc;
        e.sat = esat;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t       e;
        logic [5:0] obs;
        logic [5:0] req;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = {m_state, m_tc, m_sat};
                1:       obs = {2'b00, c2_state, c2_tc, c2_sat};
                default: obs = {3'b000, c1_state, c1_tc, c1_sat};
            endcase
            req = {e.st, e.tc, e.sat};
            checks++;
            assert (obs === req) else begin
                errors++;
                $error("FAIL %s: observed state/tc/sat=%0h/%0b/%0b required %0h/%0b/%0b",
                       e.tag, obs[5:2], obs[1], obs[0], req[5:2], req[1], req[0]);
            end
        end
    endtask

    task automatic drive(input bit trg, input bit d, input bit w,
                         input bit ld, input int lv);
        m_trig = trg;
        m_dir  = d;
        m_wrap = w;
        m_load = ld;
        m_lv   = 4'(lv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset  = 1'b0;
        c_trig = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset values (one edge has passed with reset low)
        #8;
        push("reset_main", 0, 0, 0, 0);
        push("reset_c2",   1, 0, 0, 0);
        push("reset_c1",   2, 0, 0, 0);
        check_all();

        // Release at 13 ns; count up with wrap: 1..9,0(tc),1
        #5;
        reset = 1'b1;
        drive(1, 1, 1, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            push("up_wrap", 0, i % 10, (i == 10), 0);
            tick();
        end

        // Back to 0, then count down with wrap: 9(tc),8..0,9(tc)
        drive(0, 0, 1, 1, 0);
        push("load_0", 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i <= 10; i++) begin
            push("dn_wrap", 0, 9 - (i % 10), ((i % 10) == 0), 0);
            tick();
        end

        // Up with saturation from 7: 8,9,9(sat),9(sat); then down clears sat
        drive(0, 1, 0, 1, 7);
        push("load_7", 0, 7, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0);
        push("up_sat_8", 0, 8, 0, 0); tick();
        push("up_sat_9", 0, 9, 0, 0); tick();
        push("up_sat_h1", 0, 9, 0, 1); tick();
        push("up_sat_h2", 0, 9, 0, 1); tick();
        drive(1, 0, 0, 0, 0);
        push("sat_clear_dn", 0, 8, 0, 0); tick();

        // Load clamp, load beats trigger, hold
        drive(0, 0, 0, 1, 12);
        push("load_clamp", 0, 9, 0, 0); tick();
        drive(1, 1, 0, 1, 5);
        push("load_over_trig", 0, 5, 0, 0); tick();
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push("hold", 0, 5, 0, 0);
            tick();
        end

        // sat persists through hold, load clears it; lower saturation
        drive(1, 1, 0, 1, 9);
        push("load_9", 0, 9, 0, 0); tick();
        drive(1, 1, 0, 0, 0);
        push("sat_top", 0, 9, 0, 1); tick();
        drive(0, 1, 0, 0, 0);
        push("sat_hold", 0, 9, 0, 1); tick();
        drive(0, 0, 0, 1, 0);
        push("sat_load_clr", 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0);
        push("sat_bottom", 0, 0, 0, 1); tick();
        drive(1, 1, 0, 0, 0);
        push("sat_clear_up", 0, 1, 0, 0); tick();

        // Asynchronous reset mid-operation at state 6
        drive(0, 0, 0, 1, 6);
        push("load_6", 0, 6, 0, 0); tick();
        drive(1, 1, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        push("async_rst", 0, 0, 0, 0);
        check_all();
        push("rst_hold1", 0, 0, 0, 0); tick();
        push("rst_hold2", 0, 0, 0, 0); tick();
        #4;
        reset = 1'b1;
        push("post_rst", 0, 1, 0, 0); tick();

        // Corner instances: W2/M4 counts 1,2,3,0(tc),1; W1/M2 toggles
        drive(0, 1, 1, 0, 0);
        c_trig = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push("c2_count", 1, k % 4, (k == 4), 0);
            push("c1_toggle", 2, k % 2, ((k % 2) == 0), 0);
            push("main_idle", 0, 1, 0, 0);
            tick();
        end
        c_trig = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
